// File: rtl/lfsr_checker.sv
// -----------------------------------------------------------------------------
// lfsr_checker
//
// Receive-side checker for an 8-bit XNOR LFSR stream (taps 8,6,5,4).
// It self-synchronises to the incoming state words (HUNT -> VERIFY -> LOCKED),
// then flywheels its own prediction and flags every word that disagrees.
//
// Optional feature macro: LFSR_CHK_BITERR_EN
//   When defined, adds bit_err_count, a saturating count of mismatching bits
//   accumulated while LOCKED.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   synchronous active-high reset
//   in_valid       in   in_data carries a word this cycle
//   in_data[7:0]   in   received LFSR state word
//   clear_err      in   synchronous clear of the error counters
//   sync_state[1:0] out 00 HUNT, 01 VERIFY, 10 LOCKED
//   locked         out  high while LOCKED
//   err_pulse      out  one-cycle pulse per mismatching word while LOCKED
//   err_count      out  saturating count of word errors while LOCKED
//   lockup         out  last HUNT sample was the illegal all-ones word
//   bit_err_count  out  (LFSR_CHK_BITERR_EN only) saturating bit-error count
// All outputs are registered: they reflect a word one cycle after it is seen.
// -----------------------------------------------------------------------------
module lfsr_checker #(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 3,
    parameter int unsigned ERRW       = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [7:0]      in_data,
    input  logic            clear_err,
    output logic [1:0]      sync_state,
    output logic            locked,
    output logic            err_pulse,
    output logic [ERRW-1:0] err_count,
    output logic            lockup
`ifdef LFSR_CHK_BITERR_EN
    ,
    output logic [ERRW-1:0] bit_err_count
`endif
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'b00,
        ST_VERIFY = 2'b01,
        ST_LOCKED = 2'b10
    } state_e;

    localparam logic [7:0] LOCKUP_WORD = 8'hFF;
    localparam logic [3:0] LOCK_CNT_L  = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_CNT_L  = 4'(LOSS_COUNT);
    localparam logic [ERRW-1:0] ERR_MAX = {ERRW{1'b1}};
    localparam logic [ERRW-1:0] ERR_ONE = {{(ERRW-1){1'b0}}, 1'b1};

    // Advance the sequence by one step: XNOR feedback, shifted in at bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        lfsr_next = {s[6:0], ~(s[7] ^ s[5] ^ s[4] ^ s[3])};
    endfunction

`ifdef LFSR_CHK_BITERR_EN
    // Number of set bits in a byte (0..8).
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] acc;
        acc = 4'd0;
        for (int i = 0; i < 8; i++) begin
            acc = acc + {3'b000, v[i]};
        end
        popcount8 = acc;
    endfunction
`endif

    state_e          state_q, state_d;
    logic [7:0]      pred_q, pred_d;
    logic [3:0]      match_q, match_d;
    logic [3:0]      miss_q, miss_d;
    logic            lockup_q, lockup_d;
    logic            pulse_q, pulse_d;
    logic            locked_q, locked_d;
    logic [ERRW-1:0] err_q, err_d;

    logic            hit_s;
    logic [3:0]      match_inc_s;
    logic [3:0]      miss_inc_s;
    logic [ERRW-1:0] err_inc_s;

`ifdef LFSR_CHK_BITERR_EN
    logic [ERRW-1:0] bit_q, bit_d;
    logic [ERRW:0]   bit_sum_s;
    logic [ERRW-1:0] bit_add_s;
`endif

    assign hit_s       = (in_data == pred_q);
    assign match_inc_s = match_q + 4'd1;
    assign miss_inc_s  = miss_q + 4'd1;
    assign err_inc_s   = (err_q == ERR_MAX) ? ERR_MAX : (err_q + ERR_ONE);

`ifdef LFSR_CHK_BITERR_EN
    // The carry-out bit of the widened sum signals saturation.
    assign bit_sum_s = {1'b0, bit_q} + (ERRW+1)'(popcount8(in_data ^ pred_q));
    assign bit_add_s = bit_sum_s[ERRW] ? ERR_MAX : bit_sum_s[ERRW-1:0];
`endif

    // Next-state logic for the sync FSM, predictor and error counters.
    always_comb begin
        state_d  = state_q;
        pred_d   = pred_q;
        match_d  = match_q;
        miss_d   = miss_q;
        lockup_d = lockup_q;
        pulse_d  = 1'b0;
        err_d    = err_q;
`ifdef LFSR_CHK_BITERR_EN
        bit_d    = bit_q;
`endif
        if (in_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (in_data == LOCKUP_WORD) begin
                        lockup_d = 1'b1;
                    end else begin
                        pred_d   = lfsr_next(in_data);
                        match_d  = 4'd0;
                        lockup_d = 1'b0;
                        state_d  = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (hit_s) begin
                        pred_d  = lfsr_next(pred_q);
                        match_d = match_inc_s;
                        if (match_inc_s == LOCK_CNT_L) begin
                            state_d = ST_LOCKED;
                            miss_d  = 4'd0;
                        end else begin
                            state_d = ST_VERIFY;
                        end
                    end else if (in_data != LOCKUP_WORD) begin
                        // Reseed from the offending word rather than re-hunting.
                        pred_d  = lfsr_next(in_data);
                        match_d = 4'd0;
                    end else begin
                        match_d  = 4'd0;
                        lockup_d = 1'b1;
                        state_d  = ST_HUNT;
                    end
                end
                ST_LOCKED: begin
                    // Flywheel: the prediction advances regardless of the outcome.
                    pred_d = lfsr_next(pred_q);
`ifdef LFSR_CHK_BITERR_EN
                    bit_d  = bit_add_s;
`endif
                    if (hit_s) begin
                        miss_d = 4'd0;
                    end else begin
                        pulse_d = 1'b1;
                        err_d   = err_inc_s;
                        if (miss_inc_s == LOSS_CNT_L) begin
                            miss_d  = 4'd0;
                            state_d = ST_HUNT;
                        end else begin
                            miss_d  = miss_inc_s;
                        end
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    match_d = 4'd0;
                    miss_d  = 4'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        // Clearing wins over a same-cycle increment.
        if (clear_err) begin
            err_d = {ERRW{1'b0}};
`ifdef LFSR_CHK_BITERR_EN
            bit_d = {ERRW{1'b0}};
`endif
        end else begin
            err_d = err_d;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_HUNT;
            pred_q   <= 8'h00;
            match_q  <= 4'd0;
            miss_q   <= 4'd0;
            lockup_q <= 1'b0;
            pulse_q  <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= {ERRW{1'b0}};
`ifdef LFSR_CHK_BITERR_EN
            bit_q    <= {ERRW{1'b0}};
`endif
        end else begin
            state_q  <= state_d;
            pred_q   <= pred_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
            lockup_q <= lockup_d;
            pulse_q  <= pulse_d;
            locked_q <= locked_d;
            err_q    <= err_d;
`ifdef LFSR_CHK_BITERR_EN
            bit_q    <= bit_d;
`endif
        end
    end

    assign sync_state = state_q;
    assign locked     = locked_q;
    assign err_pulse  = pulse_q;
    assign err_count  = err_q;
    assign lockup     = lockup_q;
`ifdef LFSR_CHK_BITERR_EN
    assign bit_err_count = bit_q;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// -----------------------------------------------------------------------------
// tb_lfsr_checker
//
// Table-driven bench for lfsr_checker. Each record holds the inputs for one
// cycle and the outputs expected one cycle later. Records are pushed to a
// scoreboard queue when driven and popped/compared after the clock edge.
// A narrow error counter (ERRW=4) keeps the saturation sequence short.
// -----------------------------------------------------------------------------
module tb_lfsr_checker;

    localparam int unsigned TB_ERRW = 4;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [7:0] data;
        logic       clr;
        logic [1:0] st;
        logic       lk;
        logic       pl;
        logic [3:0] cnt;
        logic       lu;
        logic [3:0] bec;
    } vec_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic [7:0]         in_data = 8'h00;
    logic               clear_err = 1'b0;
    logic [1:0]         sync_state;
    logic               locked;
    logic               err_pulse;
    logic [TB_ERRW-1:0] err_count;
    logic               lockup;
`ifdef LFSR_CHK_BITERR_EN
    logic [TB_ERRW-1:0] bit_err_count;
`endif

    int n_vec = 0;
    int n_miscmp = 0;
    vec_t exp_q[$];

    lfsr_checker #(
        .LOCK_COUNT(4),
        .LOSS_COUNT(3),
        .ERRW(TB_ERRW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_data(in_data),
        .clear_err(clear_err),
        .sync_state(sync_state),
        .locked(locked),
        .err_pulse(err_pulse),
        .err_count(err_count),
        .lockup(lockup)
`ifdef LFSR_CHK_BITERR_EN
        ,
        .bit_err_count(bit_err_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] nextf(input logic [7:0] s);
        nextf = {s[6:0], ~(s[7] ^ s[5] ^ s[4] ^ s[3])};
    endfunction

    function automatic vec_t mk(input logic rst, input logic vld, input logic [7:0] d,
                                input logic clr, input logic [1:0] st, input logic pl,
                                input logic [3:0] cnt, input logic lu, input logic [3:0] bec);
        vec_t v;
        v.rst = rst; v.vld = vld; v.data = d; v.clr = clr;
        v.st = st; v.lk = (st == 2'b10); v.pl = pl; v.cnt = cnt; v.lu = lu; v.bec = bec;
        return v;
    endfunction

    task automatic check_one();
        vec_t e;
        if (exp_q.size() == 0) begin
            n_miscmp++;
            $display("FAIL scoreboard_empty: got no expectation, need one");
        end else begin
            e = exp_q.pop_front();
            n_vec++;
            if (sync_state !== e.st) begin
                n_miscmp++;
                $display("FAIL sync_state vec%0d: got %b want %b", n_vec, sync_state, e.st);
            end
            if (locked !== e.lk) begin
                n_miscmp++;
                $display("FAIL locked vec%0d: got %b want %b", n_vec, locked, e.lk);
            end
            if (err_pulse !== e.pl) begin
                n_miscmp++;
                $display("FAIL err_pulse vec%0d: got %b want %b", n_vec, err_pulse, e.pl);
            end
            if (err_count !== e.cnt) begin
                n_miscmp++;
                $display("FAIL err_count vec%0d: got %0d want %0d", n_vec, err_count, e.cnt);
            end
            if (lockup !== e.lu) begin
                n_miscmp++;
                $display("FAIL lockup vec%0d: got %b want %b", n_vec, lockup, e.lu);
            end
`ifdef LFSR_CHK_BITERR_EN
            if (bit_err_count !== e.bec) begin
                n_miscmp++;
                $display("FAIL bit_err_count vec%0d: got %0d want %0d", n_vec, bit_err_count, e.bec);
            end
`endif
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        reset     = v.rst;
        in_valid  = v.vld;
        in_data   = v.data;
        clear_err = v.clr;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        check_one();
    endtask

    localparam logic [1:0] H = 2'b00;
    localparam logic [1:0] V = 2'b01;
    localparam logic [1:0] L = 2'b10;

    vec_t tbl[36];

    initial begin
        logic [7:0] pred;
        logic [3:0] cnt;
        logic [3:0] bec;

        //            rst  vld   data   clr   st pl cnt   lu   bec
        tbl[0]  = mk(1'b1, 1'b0, 8'h00, 1'b0, H, 1'b0, 4'd0, 1'b0, 4'd0);
        tbl[1]  = mk(1'b0, 1'b1, 8'h01, 1'b0, V, 1'b0, 4'd0, 1'b0, 4'd0);
        tbl[2]  = mk(1'b0, 1'b1, 8'h03, 1'b0, V, 1'b0, 4'd0, 1'b0, 4'd0);
        tbl[3]  = mk(1'b0, 1'b1, 8'h07, 1'b0, V, 1'b0, 4'd0, 1'b0, 4'd0);
        tbl[4]  = mk(1'b0, 1'b1, 8'h0F, 1'b0, V, 1'b0, 4'd0, 1'b0, 4'd0);
        tbl[5]  = mk(1'b0, 1'b1, 8'h1E, 1'b0, L, 1'b0, 4'd0, 1'b0, 4'd0);
        tbl[6]  = mk(1'b0, 1'b1, 8'h3D, 1'b0, L, 1'b0, 4'd0, 1'b0, 4'd0);
        tbl[7]  = mk(1'b0, 1'b1, 8'h7B, 1'b0, L, 1'b1, 4'd1, 1'b0, 4'd1);
        tbl[8]  = mk(1'b0, 1'b1, 8'hF4, 1'b0, L, 1'b0, 4'd1, 1'b0, 4'd1);
        tbl[9]  = mk(1'b0, 1'b1, 8'hE8, 1'b1, L, 1'b0, 4'd0, 1'b0, 4'd0);
        tbl[10] = mk(1'b0, 1'b0, 8'h00, 1'b0, L, 1'b0, 4'd0, 1'b0, 4'd0);
        // predictions D0, A1, 43 (3 set bits each) against 00
        tbl[11] = mk(1'b0, 1'b1, 8'h00, 1'b0, L, 1'b1, 4'd1, 1'b0, 4'd3);
        tbl[12] = mk(1'b0, 1'b1, 8'h00, 1'b0, L, 1'b1, 4'd2, 1'b0, 4'd6);
        tbl[13] = mk(1'b0, 1'b1, 8'h00, 1'b0, H, 1'b1, 4'd3, 1'b0, 4'd9);
        tbl[14] = mk(1'b0, 1'b1, 8'h01, 1'b0, V, 1'b0, 4'd3, 1'b0, 4'd9);
        tbl[15] = mk(1'b0, 1'b1, 8'h03, 1'b0, V, 1'b0, 4'd3, 1'b0, 4'd9);
        tbl[16] = mk(1'b0, 1'b1, 8'h07, 1'b0, V, 1'b0, 4'd3, 1'b0, 4'd9);
        tbl[17] = mk(1'b0, 1'b1, 8'h0F, 1'b0, V, 1'b0, 4'd3, 1'b0, 4'd9);
        tbl[18] = mk(1'b0, 1'b1, 8'h1E, 1'b0, L, 1'b0, 4'd3, 1'b0, 4'd9);
        tbl[19] = mk(1'b1, 1'b0, 8'h00, 1'b0, H, 1'b0, 4'd0, 1'b0, 4'd0);
        tbl[20] = mk(1'b0, 1'b1, 8'hFF, 1'b0, H, 1'b0, 4'd0, 1'b1, 4'd0);
        tbl[21] = mk(1'b0, 1'b1, 8'hFF, 1'b0, H, 1'b0, 4'd0, 1'b1, 4'd0);
        tbl[22] = mk(1'b0, 1'b1, 8'h01, 1'b0, V, 1'b0, 4'd0, 1'b0, 4'd0);
        tbl[23] = mk(1'b0, 1'b1, 8'h55, 1'b0, V, 1'b0, 4'd0, 1'b0, 4'd0);
        tbl[24] = mk(1'b0, 1'b1, 8'hAA, 1'b0, V, 1'b0, 4'd0, 1'b0, 4'd0);
        tbl[25] = mk(1'b0, 1'b1, 8'h54, 1'b0, V, 1'b0, 4'd0, 1'b0, 4'd0);
        tbl[26] = mk(1'b0, 1'b1, 8'hA8, 1'b0, V, 1'b0, 4'd0, 1'b0, 4'd0);
        tbl[27] = mk(1'b0, 1'b1, 8'h50, 1'b0, L, 1'b0, 4'd0, 1'b0, 4'd0);
        tbl[28] = mk(1'b1, 1'b0, 8'h00, 1'b0, H, 1'b0, 4'd0, 1'b0, 4'd0);
        tbl[29] = mk(1'b0, 1'b1, 8'h01, 1'b0, V, 1'b0, 4'd0, 1'b0, 4'd0);
        tbl[30] = mk(1'b0, 1'b1, 8'h03, 1'b0, V, 1'b0, 4'd0, 1'b0, 4'd0);
        tbl[31] = mk(1'b0, 1'b1, 8'hFF, 1'b0, H, 1'b0, 4'd0, 1'b1, 4'd0);
        tbl[32] = mk(1'b0, 1'b1, 8'h01, 1'b0, V, 1'b0, 4'd0, 1'b0, 4'd0);
        tbl[33] = mk(1'b0, 1'b1, 8'h03, 1'b0, V, 1'b0, 4'd0, 1'b0, 4'd0);
        tbl[34] = mk(1'b1, 1'b1, 8'h07, 1'b1, H, 1'b0, 4'd0, 1'b0, 4'd0);
        tbl[35] = mk(1'b0, 1'b0, 8'h07, 1'b0, H, 1'b0, 4'd0, 1'b0, 4'd0);

        for (int i = 0; i < 36; i++) begin
            apply(tbl[i]);
        end

        // Saturation: lock, then alternate wrong/right words past the counter limit.
        apply(mk(1'b1, 1'b0, 8'h00, 1'b0, H, 1'b0, 4'd0, 1'b0, 4'd0));
        apply(mk(1'b0, 1'b1, 8'h01, 1'b0, V, 1'b0, 4'd0, 1'b0, 4'd0));
        apply(mk(1'b0, 1'b1, 8'h03, 1'b0, V, 1'b0, 4'd0, 1'b0, 4'd0));
        apply(mk(1'b0, 1'b1, 8'h07, 1'b0, V, 1'b0, 4'd0, 1'b0, 4'd0));
        apply(mk(1'b0, 1'b1, 8'h0F, 1'b0, V, 1'b0, 4'd0, 1'b0, 4'd0));
        apply(mk(1'b0, 1'b1, 8'h1E, 1'b0, L, 1'b0, 4'd0, 1'b0, 4'd0));
        pred = 8'h3D;
        cnt  = 4'd0;
        bec  = 4'd0;
        for (int k = 0; k < 17; k++) begin
            cnt = (cnt == 4'd15) ? 4'd15 : cnt + 4'd1;
            bec = (bec > 4'd7) ? 4'd15 : bec + 4'd8;
            apply(mk(1'b0, 1'b1, ~pred, 1'b0, L, 1'b1, cnt, 1'b0, bec));
            pred = nextf(pred);
            apply(mk(1'b0, 1'b1, pred, 1'b0, L, 1'b0, cnt, 1'b0, bec));
            pred = nextf(pred);
        end
        // Error coincident with clear: the pulse fires, the counters still clear.
        apply(mk(1'b0, 1'b1, ~pred, 1'b1, L, 1'b1, 4'd0, 1'b0, 4'd0));
        pred = nextf(pred);
        apply(mk(1'b0, 1'b0, pred, 1'b0, L, 1'b0, 4'd0, 1'b0, 4'd0));
        apply(mk(1'b0, 1'b1, pred, 1'b0, L, 1'b0, 4'd0, 1'b0, 4'd0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
        $fatal(1, "watchdog");
    end

endmodule
